// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the six-digit seven-segment scan controller.
// Build option SEG_GHOST_BLANK_EN (consumed by seg_scan_ctrl) enables the inter-digit blanking gap.
package seg_pkg;

    localparam int NDIG = 6;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } scan_st_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit code to seven-segment pattern; code F is blank.
// Independent of build option SEG_GHOST_BLANK_EN.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit time-multiplexed seven-segment scan controller with frame-boundary shadow loads.
// Define SEG_GHOST_BLANK_EN to insert BLANK dark cycles at the start of every digit slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 16
) (
    input  logic        clk_1mhz,
    input  logic        rst_n,
    input  logic        upd_req,
    input  logic [23:0] upd_data,
    input  logic [5:0]  upd_dp,
    output logic        upd_ack,
    output logic        frame_tick,
    output logic [0:5]  dig,
    output logic [7:0]  duan
);

    localparam int unsigned CW = $clog2(DIV);

`ifdef SEG_GHOST_BLANK_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NDIG - 1);

    scan_st_t        state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [23:0]     sh_data_q, sh_data_d;
    logic [5:0]      sh_dp_q, sh_dp_d;
    logic [0:5]      dig_q, dig_d;
    logic [7:0]      duan_q, duan_d;
    logic            ack_q, ack_d;
    logic            tick_q, tick_d;

    logic            slot_end;
    logic            boundary;
    logic            blank_done;
    logic [3:0]      dcode [NDIG];
    logic [3:0]      code_sel;
    logic            dp_sel;
    logic [6:0]      seg_pat;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign boundary   = slot_end && (idx_q == IDX_LAST);
    // Without blanking OFF only exists as the reset state and is left on the first edge.
    assign blank_done = !GHOST_EN || (cnt_q == BLANK_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        ack_d     = 1'b0;
        tick_d    = boundary;

        case (state_q)
            OFF: begin
                if (blank_done) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (slot_end) begin
                    state_d = GHOST_EN ? OFF : ON;
                    idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: state_d = OFF;
        endcase

        if (boundary && upd_req) begin
            sh_data_d = upd_data;
            sh_dp_d   = upd_dp;
            ack_d     = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with the state register.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign dcode[gi] = sh_data_d[4*gi +: 4];
        assign dig_d[gi] = !((state_d == ON) && (idx_d == 3'(gi)));
    end

    always_comb begin
        code_sel = 4'hF;
        dp_sel   = 1'b0;
        case (idx_d)
            3'd0:    begin code_sel = dcode[0]; dp_sel = sh_dp_d[0]; end
            3'd1:    begin code_sel = dcode[1]; dp_sel = sh_dp_d[1]; end
            3'd2:    begin code_sel = dcode[2]; dp_sel = sh_dp_d[2]; end
            3'd3:    begin code_sel = dcode[3]; dp_sel = sh_dp_d[3]; end
            3'd4:    begin code_sel = dcode[4]; dp_sel = sh_dp_d[4]; end
            3'd5:    begin code_sel = dcode[5]; dp_sel = sh_dp_d[5]; end
            default: begin code_sel = 4'hF;     dp_sel = 1'b0;       end
        endcase
    end

    seg7_decode u_decode (
        .code_i (code_sel),
        .seg_o  (seg_pat)
    );

    assign duan_d = (state_d == ON) ? {dp_sel, seg_pat} : 8'h00;

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            sh_data_q <= {NDIG{4'hF}};
            sh_dp_q   <= 6'd0;
            dig_q     <= 6'b111111;
            duan_q    <= 8'h00;
            ack_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sh_data_q <= sh_data_d;
            sh_dp_q   <= sh_dp_d;
            dig_q     <= dig_d;
            duan_q    <= duan_d;
            ack_q     <= ack_d;
            tick_q    <= tick_d;
        end
    end

    assign dig        = dig_q;
    assign duan       = duan_q;
    assign upd_ack    = ack_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIV=10, BLANK=2.
// Expectations follow SEG_GHOST_BLANK_EN when the bench is built with it.
module tb_seg_scan_ctrl;

    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int NDIG  = 6;

`ifdef SEG_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        upd_req;
    logic [23:0] upd_data;
    logic [5:0]  upd_dp;
    logic        upd_ack;
    logic        frame_tick;
    logic [0:5]  dig;
    logic [7:0]  duan;

    int checks  = 0;
    int errors  = 0;
    int kpos    = 0;
    int ack_cnt = 0;

    seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk_1mhz   (clk),
        .rst_n      (rst_n),
        .upd_req    (upd_req),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .upd_ack    (upd_ack),
        .frame_tick (frame_tick),
        .dig        (dig),
        .duan       (duan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (upd_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int kt);
        step(kt - kpos);
        kpos = kt;
    endtask

    task automatic wait_frame(output logic ack_seen, output int nsteps);
        bit found;
        found    = 1'b0;
        ack_seen = 1'b0;
        nsteps   = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            nsteps++;
            if (frame_tick === 1'b1) begin
                found    = 1'b1;
                ack_seen = upd_ack;
            end
        end
        kpos = 0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_tick_timeout: no frame_tick within %0d cycles", nsteps);
        end
    endtask

    task automatic test_reset();
        logic [0:5] exp_dig;
        rst_n    = 1'b0;
        upd_req  = 1'b0;
        upd_data = 24'h0;
        upd_dp   = 6'h0;
        step(3);
        checks++; if (dig !== 6'b111111) begin errors++; $display("FAIL reset_dig got %b want 111111", dig); end
        checks++; if (duan !== 8'h00) begin errors++; $display("FAIL reset_duan got %h want 00", duan); end
        checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", upd_ack); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        rst_n = 1'b1;
        kpos  = 0;
        for (int i = 0; i < NDIG; i++) begin
            goto(10 * i + 5);
            exp_dig    = 6'b111111;
            exp_dig[i] = 1'b0;
            checks++; if (dig !== exp_dig) begin errors++; $display("FAIL idle_dig%0d got %b want %b", i, dig, exp_dig); end
            checks++; if (duan !== 8'h00) begin errors++; $display("FAIL idle_duan%0d got %h want 00", i, duan); end
        end
        goto(59);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL early_tick got %b want 0", frame_tick); end
        goto(60);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", frame_tick); end
        kpos = 0;
        $display("test_reset done");
    endtask

    task automatic test_frame_load();
        logic [7:0] exp_duan [NDIG];
        logic [0:5] exp_dig;
        logic       a;
        int         n, c0;
        exp_duan = '{8'h3F, 8'h06, 8'hDB, 8'h4F, 8'h66, 8'h6D};
        c0       = ack_cnt;
        upd_data = 24'h543210;
        upd_dp   = 6'b000100;
        upd_req  = 1'b1;
        wait_frame(a, n);
        upd_req = 1'b0;
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL load_ack_with_tick got %b want 1", a); end
        goto(2);
        checks++; if (duan !== 8'h3F || dig !== 6'b011111) begin errors++; $display("FAIL load_first_on got %b/%h want 011111/3f", dig, duan); end
        for (int i = 0; i < NDIG; i++) begin
            goto(10 * i + 5);
            exp_dig    = 6'b111111;
            exp_dig[i] = 1'b0;
            checks++;
            if (dig !== exp_dig || duan !== exp_duan[i]) begin
                errors++;
                $display("FAIL load_digit%0d got %b/%h want %b/%h", i, dig, duan, exp_dig, exp_duan[i]);
            end
        end
        checks++; if (ack_cnt - c0 !== 1) begin errors++; $display("FAIL load_ack_count got %0d want 1", ack_cnt - c0); end
        $display("test_frame_load done");
    endtask

    task automatic test_blanking();
        logic a;
        int   n, nblank, nact;
        wait_frame(a, n);
        goto(10);
        nblank = 0;
        nact   = 0;
        for (int i = 0; i < DIV; i++) begin
            if (dig === 6'b111111) nblank++;
            if (dig === 6'b101111) nact++;
            step(1);
            kpos++;
        end
        checks++; if (nblank != (GHOST ? BLANK : 0)) begin errors++; $display("FAIL blank_cycles got %0d want %0d", nblank, GHOST ? BLANK : 0); end
        checks++; if (nact != (GHOST ? DIV - BLANK : DIV)) begin errors++; $display("FAIL active_cycles got %0d want %0d", nact, GHOST ? DIV - BLANK : DIV); end
        wait_frame(a, n);
        wait_frame(a, n);
        checks++; if (n != 6 * DIV) begin errors++; $display("FAIL frame_length got %0d want %0d", n, 6 * DIV); end
        $display("test_blanking done");
    endtask

    task automatic test_dropped();
        logic a;
        int   n, c0;
        c0 = ack_cnt;
        goto(20);
        upd_data = 24'h999999;
        upd_dp   = 6'b111111;
        upd_req  = 1'b1;
        goto(30);
        upd_req = 1'b0;
        wait_frame(a, n);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL drop_ack got %b want 0", a); end
        goto(5);
        checks++; if (dig !== 6'b011111 || duan !== 8'h3F) begin errors++; $display("FAIL drop_digit0 got %b/%h want 011111/3f", dig, duan); end
        goto(25);
        checks++; if (dig !== 6'b110111 || duan !== 8'hDB) begin errors++; $display("FAIL drop_digit2 got %b/%h want 110111/db", dig, duan); end
        checks++; if (ack_cnt != c0) begin errors++; $display("FAIL drop_ack_count got %0d want 0", ack_cnt - c0); end
        $display("test_dropped done");
    endtask

    task automatic test_reset_mid();
        logic [0:5] exp_dig;
        logic       a;
        int         n, c0;
        wait_frame(a, n);
        goto(35);
        checks++; if (dig !== 6'b111011) begin errors++; $display("FAIL mid_pre_dig got %b want 111011", dig); end
        c0       = ack_cnt;
        upd_data = 24'h777777;
        upd_dp   = 6'b111111;
        upd_req  = 1'b1;
        rst_n    = 1'b0;
        #1;
        checks++; if (dig !== 6'b111111 || duan !== 8'h00) begin errors++; $display("FAIL mid_async got %b/%h want 111111/00", dig, duan); end
        checks++; if (upd_ack !== 1'b0 || frame_tick !== 1'b0) begin errors++; $display("FAIL mid_async_pulses got %b%b want 00", upd_ack, frame_tick); end
        @(negedge clk);
        upd_req = 1'b0;
        step(1);
        rst_n = 1'b1;
        kpos  = 0;
        for (int i = 0; i < NDIG; i++) begin
            goto(10 * i + 5);
            exp_dig    = 6'b111111;
            exp_dig[i] = 1'b0;
            checks++;
            if (dig !== exp_dig || duan !== 8'h00) begin
                errors++;
                $display("FAIL mid_after_digit%0d got %b/%h want %b/00", i, dig, duan, exp_dig);
            end
        end
        checks++; if (ack_cnt != c0) begin errors++; $display("FAIL mid_ack_count got %0d want 0", ack_cnt - c0); end
        $display("test_reset_mid done");
    endtask

    task automatic test_held();
        logic a;
        int   n, c0;
        c0       = ack_cnt;
        upd_data = 24'hEDCBA9;
        upd_dp   = 6'b000001;
        upd_req  = 1'b1;
        wait_frame(a, n);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL held_ack1 got %b want 1", a); end
        upd_data = 24'h012345;
        upd_dp   = 6'b100000;
        goto(5);
        checks++; if (duan !== 8'hEF) begin errors++; $display("FAIL held_f1_d0 got %h want ef", duan); end
        goto(55);
        checks++; if (duan !== 8'h79) begin errors++; $display("FAIL held_f1_d5 got %h want 79", duan); end
        wait_frame(a, n);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL held_ack2 got %b want 1", a); end
        upd_data = 24'hFFFFF8;
        upd_dp   = 6'b000000;
        goto(5);
        checks++; if (duan !== 8'h6D) begin errors++; $display("FAIL held_f2_d0 got %h want 6d", duan); end
        goto(55);
        checks++; if (duan !== 8'hBF) begin errors++; $display("FAIL held_f2_d5 got %h want bf", duan); end
        wait_frame(a, n);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL held_ack3 got %b want 1", a); end
        upd_req = 1'b0;
        goto(5);
        checks++; if (duan !== 8'h7F) begin errors++; $display("FAIL held_f3_d0 got %h want 7f", duan); end
        goto(15);
        checks++; if (dig !== 6'b101111 || duan !== 8'h00) begin errors++; $display("FAIL held_f3_d1 got %b/%h want 101111/00", dig, duan); end
        wait_frame(a, n);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL held_after_release_ack got %b want 0", a); end
        goto(5);
        checks++; if (ack_cnt - c0 != 3) begin errors++; $display("FAIL held_ack_count got %0d want 3", ack_cnt - c0); end
        $display("test_held done");
    endtask

    initial begin
        rst_n    = 1'b0;
        upd_req  = 1'b0;
        upd_data = 24'h0;
        upd_dp   = 6'h0;
        @(negedge clk);
        test_reset();
        test_frame_load();
        test_blanking();
        test_dropped();
        test_reset_mid();
        test_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the player's six-digit seven-segment display. It holds a shadow copy of six 4-bit digit codes and six decimal points. It drives one digit at a time through the shared `dig`/`duan` pins at a fixed slot rate, with an optional blanking gap between digits to suppress ghosting. Upstream producers (note display, track number, play time) hand it new frames through a request/acknowledge handshake. Loads happen only at frame boundaries, so a frame is never torn.

## Interface
- `DIV`, default 1000: clk_1mhz cycles per digit slot; legal range 2..65535.
- `BLANK`, default 16: blanking cycles at the start of each slot; legal range 1..DIV-1.
- `clk_1mhz` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `upd_req` in 1: request to load a new frame; held high until `upd_ack`.
- `upd_data` in 24: digit i code in bits [4i+3:4i].
- `upd_dp` in 6: decimal point for digit i in bit i.
- `upd_ack` out 1: one-cycle pulse; the frame was loaded.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.
- `dig` out [0:5]: digit select, active-low; `dig[i]`=0 selects digit i.
- `duan` out 8: segments {dp,g,f,e,d,c,b,a}, active-high.

## Operation
- Shadow registers: `sh_data[23:0]` and `sh_dp[5:0]`. Reset value is all digits 4'hF (blank) and dp 0.
- Index counter `idx` counts 0..5 and wraps to 0. Slot counter `cnt` counts 0..DIV-1.
- Two-state FSM, OFF and ON.
  - OFF: `dig`=6'b111111, `duan`=8'h00. When `cnt`=BLANK-1, go to ON.
  - ON: `dig` has only bit `idx` low; `duan`={sh_dp[idx], seg7(sh_data[idx])}. When `cnt`=DIV-1, set `cnt` to 0, advance `idx`, and go to OFF.
- Decode table, digit code to segments:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79
  - F→00 (blank, dp still honoured)
- Frame boundary: the edge at which `idx`=5 and `cnt`=DIV-1.
  - `frame_tick` pulses at this edge.
  - If `upd_req`=1 at this edge: load `sh_data`/`sh_dp` from `upd_data`/`upd_dp` and pulse `upd_ack` in the same cycle.
- `upd_req` is sampled only at the frame boundary.
  - A request dropped before the boundary is ignored: no load, no ack.
  - A request held across several boundaries loads and acks once per frame.
- `upd_data` may change freely while `upd_req`=0.

## Timing
- All outputs are registered.
- Reset values: `dig`=6'b111111, `duan`=8'h00, `upd_ack`=0, `frame_tick`=0, FSM=OFF, `idx`=0, `cnt`=0.
- Slot length is exactly DIV cycles: BLANK cycles OFF, then DIV-BLANK cycles ON.
- Frame length is 6·DIV cycles; the default is 6 ms per frame (166.7 Hz refresh).
- Update latency: `upd_ack` comes 1 to 6·DIV cycles after `upd_req` rises. The new data is visible on the first ON cycle of digit 0 after the ack.
- Reset is asynchronous. Asserting `rst_n` mid-slot forces all outputs to their reset values immediately and discards any pending request. After release, scanning restarts at digit 0 in OFF.

## Configuration
- `SEG_GHOST_BLANK_EN` defined: the OFF state and BLANK parameter are used as described.
- Macro absent: the FSM never enters OFF, the BLANK parameter is ignored, and each slot is DIV cycles ON.
- Frame length, boundary and handshake are identical in both builds.

## Structure
- Package `seg_pkg` holds:
  - the segment-pattern constants (SEG_0..SEG_E, SEG_BLANK);
  - the FSM state typedef (`scan_st_t`: OFF, ON);
  - the digit count constant NDIG=6.
- Sub-module `seg7_decode`: combinational 4-bit code to 7-segment pattern. It is instantiated once and fed by the `idx` mux.
- `cnt` width is $clog2(DIV).

## Test plan
1. Reset and idle scan: hold `rst_n`=0 → `dig`=111111, `duan`=00. Release with no request → `dig` walks 011111..111110 each slot, `duan` stays 00.
2. Frame load with DIV=10, BLANK=2, macro on:
   - stimulus: `upd_data`=24'h543210, `upd_dp`=6'b000100, `upd_req` held;
   - `upd_ack` pulses once, coincident with `frame_tick`;
   - next frame: digit0 shows `dig`=011111/`duan`=3F, digit1 shows 06, digit2 shows 0xDB.
3. Blanking with DIV=10, BLANK=2: macro on → each slot is 2 cycles `dig`=111111 then 8 cycles active. Macro off → 10 active cycles per slot, frame still 60 cycles.
4. Dropped request: raise `upd_req` mid-frame, lower it before the boundary → no `upd_ack`, display unchanged.
5. Reset mid-slot: assert `rst_n` during digit 3 ON → outputs reach reset values with no clock edge. After release, digit 0 comes first and all digits are blank.
6. Held request: keep `upd_req`=1 for 3 frames with data changing each frame → 3 `upd_ack` pulses, each frame showing the data present at its boundary.
